// File: rtl/ram_block_reader.sv
// ram_block_reader: block-transfer read engine for the dual-port data RAM.
//   Walks iBaseAddress .. iBaseAddress+iLength-1 (wrapping modulo 2^ADDR_WIDTH)
//   on oReadAddress. It absorbs the RAM's one-cycle registered read latency and
//   streams the words on oData/oValid/iReady. A two-entry skid buffer catches RAM
//   output while the consumer stalls.
// Latency: iStart sampled at E0; first read issued in cycle 1; oValid in cycle 3.
//   With iReady held high it delivers one word per cycle. oDone pulses in the
//   cycle after the final transfer.
// Backpressure: issue is throttled so that buffered + in-flight words never
//   exceed two. The RAM output is never lost, and oData holds while stalled.
// Ports: Clock/Reset (sync, active-high); iStart/iBaseAddress/iLength command;
//   oReadAddress/iRamData RAM side; oData/oValid/iReady stream; oBusy/oDone
//   status; oChecksum.
// Optional feature: define RAM_READER_CHECKSUM_EN to make oChecksum a running
//   sum of transferred words. Otherwise oChecksum is tied to 0.
module ram_block_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iStart,
  input  logic [ADDR_WIDTH-1:0] iBaseAddress,
  input  logic [ADDR_WIDTH-1:0] iLength,
  output logic [ADDR_WIDTH-1:0] oReadAddress,
  input  logic [DATA_WIDTH-1:0] iRamData,
  output logic [DATA_WIDTH-1:0] oData,
  output logic                  oValid,
  input  logic                  iReady,
  output logic                  oBusy,
  output logic                  oDone,
  output logic [DATA_WIDTH-1:0] oChecksum
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] remaining;
  logic                  in_flight;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] slot [0:1];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            count;
  logic                  pop;
  logic                  push;
  logic                  issue;
  logic                  finish;
  logic                  start_ok;
  logic                  drained;
  logic [2:0]            occupancy;

  assign pop      = oValid && iReady;
  // The word read last cycle arrives now and must be stored at this edge.
  assign push     = in_flight;
  assign start_ok = (state == IDLE) && iStart;
  // Occupancy after this cycle's pop, before any new issue. A new read is only
  // allowed if its word is guaranteed a slot when it lands.
  assign occupancy = {1'b0, count} + {2'b00, in_flight} - {2'b00, pop};
  // Evaluated post-pop, so oDone lands in the cycle right after the final transfer.
  assign drained  = !in_flight && ((count == 2'd0) || ((count == 2'd1) && pop));

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (iStart) begin
          state_next = (iLength != '0) ? RUN : DRAIN;
        end
      end
      RUN: begin
        if (occupancy < 3'd2) begin
          issue = 1'b1;
          if (remaining == ADDR_WIDTH'(1)) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (drained) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      in_flight <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      count     <= 2'd0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      slot[0]   <= '0;
      slot[1]   <= '0;
    end else begin
      state     <= state_next;
      in_flight <= issue;
      done      <= finish;

      if (start_ok) begin
        addr      <= iBaseAddress;
        remaining <= iLength;
        // A zero-length command completes without ever showing busy.
        busy      <= (iLength != '0);
      end else if (issue) begin
        addr      <= addr + ADDR_WIDTH'(1);
        remaining <= remaining - ADDR_WIDTH'(1);
      end

      if (finish) begin
        busy <= 1'b0;
      end

      if (push) begin
        slot[wr_ptr] <= iRamData;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign oReadAddress = addr;
  assign oData        = slot[rd_ptr];
  assign oValid       = (count != 2'd0);
  assign oBusy        = busy;
  assign oDone        = done;

`ifdef RAM_READER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sum <= '0;
    end else if (start_ok) begin
      sum <= '0;
    end else if (pop) begin
      sum <= sum + oData;
    end
  end

  assign oChecksum = sum;
`else
  assign oChecksum = '0;
`endif

  // A push into a full buffer with no pop would lose RAM data.
  assert property (@(posedge Clock) disable iff (Reset)
                   !(push && !pop && (count == 2'd2)));

endmodule

// File: tb/tb_ram_block_reader.sv
// tb_ram_block_reader: table-driven bench for ram_block_reader.
//   It models the RAM as word[a] = a[7:0] with a one-cycle registered read.
//   Expected words are queued when a command is driven. A negedge monitor pops
//   and compares them on each transfer and checks stall stability, first-valid
//   and oDone timing, busy and checksum.
module tb_ram_block_reader;

  localparam int DW = 8;
  localparam int AW = 10;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          iStart = 1'b0;
  logic          iReady = 1'b0;
  logic [AW-1:0] iBaseAddress = '0;
  logic [AW-1:0] iLength = '0;
  logic [AW-1:0] oReadAddress;
  logic [DW-1:0] iRamData = '0;
  logic [DW-1:0] oData;
  logic [DW-1:0] oChecksum;
  logic          oValid;
  logic          oBusy;
  logic          oDone;

  always #5 Clock = ~Clock;

  always @(posedge Clock) iRamData <= oReadAddress[7:0];

  ram_block_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .Clock(Clock), .Reset(Reset), .iStart(iStart),
    .iBaseAddress(iBaseAddress), .iLength(iLength),
    .oReadAddress(oReadAddress), .iRamData(iRamData),
    .oData(oData), .oValid(oValid), .iReady(iReady),
    .oBusy(oBusy), .oDone(oDone), .oChecksum(oChecksum)
  );

  typedef struct {
    logic [AW-1:0] base;
    int            len;
    int            mode;        // 0: ready high, 1: stall pattern, 2: random
    int            restart_at;  // loop index of an ignored iStart, -1 for none
    logic [DW-1:0] sum;
  } vec_t;

  vec_t          tbl [6];
  int            n_cmp = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            t0 = 0;
  bit            mon_en = 1'b0;
  logic [DW-1:0] exp_q [$];
  logic [AW-1:0] exp_base = '0;
  int            exp_len = 0;
  int            first_v = -1;
  int            done_rel = -1;
  int            n_done = 0;
  bit            got_done = 1'b0;
  bit            busy_seen = 1'b0;
  bit            stall_prev = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [DW-1:0] done_sum = '0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic ready_at(input int mode, input int k);
    logic [5:0] pat;
    int         j;
    pat = 6'b101001;  // 1,0,0,1,0,1 starting with the first word
    j   = k - 2;
    if (mode == 0) return 1'b1;
    if (mode == 2) return 1'($urandom_range(0, 1));
    if (j < 0) return 1'b1;
    if (j < 6) return pat[j[2:0]];
    if (j >= 8 && j < 13) return 1'b0;
    return 1'b1;
  endfunction

  always @(negedge Clock) begin
    if (mon_en) begin
      int rel;
      logic [DW-1:0] e;
      rel = cyc - t0 + 1;
      busy_seen = busy_seen | oBusy;
      if (rel == 1 && exp_len != 0) begin
        chk("busy_cycle1", 32'(oBusy), 32'd1);
        chk("addr_cycle1", 32'(oReadAddress), 32'(exp_base));
      end
      if (oValid && first_v < 0) first_v = rel;
      if (stall_prev) begin
        chk("stall_valid", 32'(oValid), 32'd1);
        chk("stall_data", 32'(oData), 32'(prev_data));
      end
      if (oValid && iReady) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL extra_word: got %0h expected no word", oData);
        end else begin
          e = exp_q.pop_front();
          chk("data", 32'(oData), 32'(e));
        end
      end
      stall_prev = oValid && !iReady;
      prev_data  = oData;
      if (oDone) begin
        n_done++;
        done_rel = rel;
        done_sum = oChecksum;
        got_done = 1'b1;
        chk("busy_at_done", 32'(oBusy), 32'd0);
      end
    end
  end

  task automatic run_vec(input vec_t v);
    logic [DW-1:0] exp_sum;
    logic [AW-1:0] a;
    int            k;
`ifdef RAM_READER_CHECKSUM_EN
    exp_sum = v.sum;
`else
    exp_sum = '0;
`endif
    @(posedge Clock); #1;
    iStart = 1'b1; iBaseAddress = v.base; iLength = AW'(v.len); iReady = 1'b1;
    for (int i = 0; i < v.len; i++) begin
      a = v.base + AW'(i);
      exp_q.push_back(a[7:0]);
    end
    exp_base = v.base; exp_len = v.len;
    @(posedge Clock); #1;
    iStart = 1'b0; t0 = cyc; first_v = -1; done_rel = -1; n_done = 0;
    got_done = 1'b0; busy_seen = 1'b0; stall_prev = 1'b0; mon_en = 1'b1;
    k = 0;
    while (!got_done && k < 200) begin
      iReady = ready_at(v.mode, k);
      if (k == v.restart_at) begin
        iStart = 1'b1; iBaseAddress = 10'h200; iLength = 10'd3;
      end else begin
        iStart = 1'b0;
      end
      @(posedge Clock); #1;
      k++;
    end
    iStart = 1'b0; iReady = 1'b1;
    @(negedge Clock);
    mon_en = 1'b0;
    chk("done_seen", 32'(got_done), 32'd1);
    chk("words_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    chk("done_count", 32'(n_done), 32'd1);
    chk("checksum_done", 32'(done_sum), 32'(exp_sum));
    chk("checksum_hold", 32'(oChecksum), 32'(exp_sum));
    if (v.len == 0) begin
      chk("len0_no_valid", 32'(first_v), 32'hFFFF_FFFF);
      chk("len0_no_busy", 32'(busy_seen), 32'd0);
      chk("len0_done_at", 32'(done_rel), 32'd2);
    end else if (v.mode == 0) begin
      chk("first_valid_at", 32'(first_v), 32'd3);
      chk("done_at", 32'(done_rel), 32'(v.len + 3));
    end
  endtask

  initial begin
    tbl[0] = '{10'h010, 4,  0, -1, 8'h46};
    tbl[1] = '{10'h020, 8,  1, -1, 8'h1C};
    tbl[2] = '{10'h3FE, 4,  0, -1, 8'hFE};
    tbl[3] = '{10'h100, 0,  0, -1, 8'h00};
    tbl[4] = '{10'h050, 6,  0,  2, 8'hEF};
    tbl[5] = '{10'h0F0, 20, 2, -1, 8'h7E};

    // Reset state
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    chk("rst_valid", 32'(oValid), 32'd0);
    chk("rst_busy", 32'(oBusy), 32'd0);
    chk("rst_done", 32'(oDone), 32'd0);
    chk("rst_data", 32'(oData), 32'd0);
    chk("rst_addr", 32'(oReadAddress), 32'd0);
    chk("rst_sum", 32'(oChecksum), 32'd0);
    @(posedge Clock); #1;
    Reset = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // Reset after three of ten words
    @(posedge Clock); #1;
    iStart = 1'b1; iBaseAddress = 10'h000; iLength = 10'd10; iReady = 1'b1;
    @(posedge Clock); #1;
    iStart = 1'b0;
    repeat (2) @(posedge Clock);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      chk("pre_rst_valid", 32'(oValid), 32'd1);
      chk("pre_rst_data", 32'(oData), 32'(i));
      @(posedge Clock);
    end
    #1;
    Reset = 1'b1; iReady = 1'b0;
    @(posedge Clock); #1;
    Reset = 1'b0; iReady = 1'b1;
    @(negedge Clock);
    chk("mid_rst_valid", 32'(oValid), 32'd0);
    chk("mid_rst_busy", 32'(oBusy), 32'd0);
    chk("mid_rst_done", 32'(oDone), 32'd0);
    run_vec('{10'h000, 2, 0, -1, 8'h01});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
